// File: rtl/mdbrot_pkg.sv
// Shared types and helpers for the multi-engine Mandelbrot pixel scheduler.
package mdbrot_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;

  localparam int unsigned X_MAX_DEF = 160;
  localparam int unsigned Y_MAX_DEF = 120;

  // In-set points plot black; otherwise the low three bits pick the colour,
  // with black remapped to white so escaping points never look in-set.
  function automatic logic [2:0] iter_to_colour(input logic [31:0] iter,
                                                input logic [31:0] max_iter);
    logic [2:0] low;
    low = iter[2:0];
    if (iter == max_iter) return 3'b000;
    return (low == 3'b000) ? 3'b111 : low;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a registered pointer,
// pointer moves to one past the winner after each grant.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_any
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;

  always_comb begin : pick
    int unsigned c;
    c         = 0;
    grant     = '0;
    grant_any = 1'b0;
    ptr_nxt   = ptr;
    for (int unsigned k = 0; k < N; k++) begin
      c = (32'(ptr) + k) % N;
      if (!grant_any && req[c]) begin
        grant[c]  = 1'b1;
        grant_any = 1'b1;
        ptr_nxt   = PW'((c + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/mdbrot_pixel_scheduler.sv
// Frame sequencer: dispatches raster pixels to N_ENG iteration engines and
// funnels their results, one per cycle, onto the VGA plot port.
module mdbrot_pixel_scheduler
  import mdbrot_pkg::*;
#(
  parameter int unsigned N_ENG    = 4,
  parameter int unsigned X_MAX    = X_MAX_DEF,
  parameter int unsigned Y_MAX    = Y_MAX_DEF,
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    done,
  output logic [N_ENG-1:0]        eng_go,
  output logic [7:0]              eng_px,
  output logic [6:0]              eng_py,
  input  logic [N_ENG-1:0]        eng_res_valid,
  input  logic [N_ENG*ITER_W-1:0] eng_res_iter,
  output logic [N_ENG-1:0]        eng_res_ack,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [2:0]              vga_colour,
  output logic                    vga_plot
);

  localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
  localparam logic [6:0] Y_LAST = 7'(Y_MAX - 1);

  sched_state_t state, state_nxt;

  logic [7:0]        cnt_x;
  logic [6:0]        cnt_y;
  logic [N_ENG-1:0]  busy;
  logic [7:0]        coord_x [N_ENG];
  logic [6:0]        coord_y [N_ENG];

  logic [N_ENG-1:0]  go_sel;
  logic              go_any;
  logic              last_px;
  logic              frame_start;
  logic [N_ENG-1:0]  req;
  logic [N_ENG-1:0]  grant;
  logic              grant_any;
  logic [ITER_W-1:0] sel_iter;
  logic [7:0]        sel_x;
  logic [6:0]        sel_y;

  assign last_px     = (cnt_x == X_LAST) && (cnt_y == Y_LAST);
  assign frame_start = ((state == IDLE) || (state == DONE)) && start;
  assign done        = (state == DONE);

  // Lowest-index free engine; busy is the registered copy, so an engine acked
  // this cycle only becomes a dispatch candidate on the following cycle.
  always_comb begin
    go_sel = '0;
    go_any = 1'b0;
    if (state == RUN) begin
      for (int unsigned i = 0; i < N_ENG; i++) begin
        if (!go_any && !busy[i]) begin
          go_sel[i] = 1'b1;
          go_any    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req = '0;
    if ((state == RUN) || (state == DRAIN)) req = eng_res_valid & busy;
  end

  rr_arbiter #(.N(N_ENG)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_any (grant_any)
  );

  always_comb begin
    sel_iter = '0;
    sel_x    = '0;
    sel_y    = '0;
    for (int unsigned i = 0; i < N_ENG; i++) begin
      if (grant[i]) begin
        sel_iter = eng_res_iter[i*ITER_W +: ITER_W];
        sel_x    = coord_x[i];
        sel_y    = coord_y[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (go_any && last_px) state_nxt = DRAIN;
      DRAIN:   if (busy == '0) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_x       <= '0;
      cnt_y       <= '0;
      busy        <= '0;
      eng_go      <= '0;
      eng_px      <= '0;
      eng_py      <= '0;
      eng_res_ack <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      for (int unsigned i = 0; i < N_ENG; i++) begin
        coord_x[i] <= '0;
        coord_y[i] <= '0;
      end
    end else begin
      eng_go      <= go_sel;
      eng_res_ack <= grant;
      vga_plot    <= grant_any;
      busy        <= (busy | go_sel) & ~grant;

      if (frame_start) begin
        cnt_x <= '0;
        cnt_y <= '0;
      end else if (go_any) begin
        eng_px <= cnt_x;
        eng_py <= cnt_y;
        if (cnt_x == X_LAST) begin
          cnt_x <= '0;
          cnt_y <= (cnt_y == Y_LAST) ? '0 : cnt_y + 7'd1;
        end else begin
          cnt_x <= cnt_x + 8'd1;
        end
      end

      for (int unsigned i = 0; i < N_ENG; i++) begin
        if (go_sel[i]) begin
          coord_x[i] <= cnt_x;
          coord_y[i] <= cnt_y;
        end
      end

      if (grant_any) begin
        vga_x      <= sel_x;
        vga_y      <= sel_y;
        vga_colour <= iter_to_colour(32'(sel_iter), 32'(MAX_ITER));
      end
    end
  end

endmodule

// File: tb/tb_mdbrot_pixel_scheduler.sv
// Directed bench: 2 engines on a 4x2 frame with reactive engine models,
// raster/plot monitors and hand-computed colour tables.
module tb_mdbrot_pixel_scheduler;

  localparam int LAT = 5;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        done;
  logic [1:0]  eng_go;
  logic [7:0]  eng_px;
  logic [6:0]  eng_py;
  logic [1:0]  eng_res_valid;
  logic [15:0] eng_res_iter;
  logic [1:0]  eng_res_ack;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  logic [7:0] iter_tab [8];
  logic [2:0] col_tab  [8];
  logic [1:0] rel;
  logic [1:0] busy_m;
  int         cnt   [2];
  logic [7:0] ex    [2];
  logic [6:0] ey    [2];

  logic        seen  [8];
  int unsigned disp_n;
  int unsigned plot_n;
  logic [7:0]  plot_x   [16];
  logic [6:0]  plot_y   [16];
  int unsigned plot_cyc [16];
  int unsigned rel_cyc;

  mdbrot_pixel_scheduler #(
    .N_ENG    (2),
    .X_MAX    (4),
    .Y_MAX    (2),
    .ITER_W   (8),
    .MAX_ITER (255)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .done          (done),
    .eng_go        (eng_go),
    .eng_px        (eng_px),
    .eng_py        (eng_py),
    .eng_res_valid (eng_res_valid),
    .eng_res_iter  (eng_res_iter),
    .eng_res_ack   (eng_res_ack),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_plot      (vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int i);
    return busy_m[i] && (cnt[i] == 0) && !eng_res_valid[i];
  endfunction

  // Engine models: act on the falling edge so results are stable at posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      eng_res_valid = '0;
      eng_res_iter  = '0;
      busy_m        = '0;
      for (int i = 0; i < 2; i++) cnt[i] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (eng_res_ack[i]) begin
          check("ack_while_valid", 32'(eng_res_valid[i]), 1);
          check("ack_go_overlap", 32'(eng_go[i]), 0);
          eng_res_valid[i] = 1'b0;
          busy_m[i] = 1'b0;
        end
        if (eng_go[i]) begin
          check("go_to_free_engine", 32'(busy_m[i]), 0);
          busy_m[i] = 1'b1;
          cnt[i] = LAT;
          ex[i] = eng_px;
          ey[i] = eng_py;
        end else if (busy_m[i] && cnt[i] != 0) begin
          cnt[i] = cnt[i] - 1;
        end
        if (busy_m[i] && cnt[i] == 0 && !eng_res_valid[i] && rel[i]) begin
          eng_res_valid[i] = 1'b1;
          eng_res_iter[i*8 +: 8] = iter_tab[{ey[i][0], ex[i][1:0]}];
        end
      end
    end
  end

  // Dispatch raster order and plot-once/colour monitors.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_go != 2'b00) begin
        check("go_onehot", 32'($onehot(eng_go)), 1);
        check("go_count_in_frame", 32'(disp_n < 8), 1);
        check("go_x", 32'(eng_px), disp_n % 4);
        check("go_y", 32'(eng_py), disp_n / 4);
        disp_n++;
      end
      if (vga_plot) begin
        check("plot_in_range", 32'((vga_x < 4) && (vga_y < 2)), 1);
        check("plot_once", 32'(seen[{vga_y[0], vga_x[1:0]}]), 0);
        seen[{vga_y[0], vga_x[1:0]}] = 1'b1;
        check("colour", 32'(vga_colour), 32'(col_tab[{vga_y[0], vga_x[1:0]}]));
        if (plot_n < 16) begin
          plot_x[plot_n]   = vga_x;
          plot_y[plot_n]   = vga_y;
          plot_cyc[plot_n] = cyc;
        end
        plot_n++;
      end
    end
  end

  task automatic new_frame();
    for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    disp_n = 0;
    plot_n = 0;
  endtask

  task automatic set_const_iter(input logic [7:0] it, input logic [2:0] col);
    for (int i = 0; i < 8; i++) begin
      iter_tab[i] = it;
      col_tab[i]  = col;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 1);
  endtask

  task automatic wait_plots(input string tag, input int unsigned want);
    int unsigned n = 0;
    while (plot_n < want && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(plot_n >= want), 1);
  endtask

  task automatic wait_both_rdy(input string tag);
    int unsigned n = 0;
    while (!(rdy(0) && rdy(1)) && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(rdy(0) && rdy(1)), 1);
  endtask

  initial begin
    int unsigned n;
    rst_n = 1'b0;
    start = 1'b0;
    rel   = 2'b11;
    set_const_iter(8'd3, 3'b011);
    new_frame();
    repeat (3) tick();

    check("rst_done", 32'(done), 0);
    check("rst_eng_go", 32'(eng_go), 0);
    check("rst_ack", 32'(eng_res_ack), 0);
    check("rst_plot", 32'(vga_plot), 0);
    check("rst_vga_xy", {vga_x, 1'b0, vga_y, 5'b0, vga_colour}, 0);
    check("rst_eng_pxy", {eng_px, 1'b0, eng_py}, 0);
    rst_n = 1'b1;
    tick();

    // Frame with every engine returning 3.
    new_frame();
    pulse_start();
    wait_done("t1_done");
    check("t1_plots", plot_n, 8);
    check("t1_dispatches", disp_n, 8);

    // Colour mapping table; start from DONE must drop done on the same edge.
    iter_tab = '{8'd3, 8'd255, 8'd8, 8'd13, 8'd0, 8'd7, 8'd16, 8'd254};
    col_tab  = '{3'd3, 3'd0,   3'd7, 3'd5,  3'd7, 3'd7, 3'd7,  3'd6};
    new_frame();
    pulse_start();
    check("t2_done_fall", 32'(done), 0);
    wait_done("t2_done");
    check("t2_plots", plot_n, 8);

    // Arbitration order with simultaneous results, pointer 0 then pointer 1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_const_iter(8'd3, 3'b011);
    rel = 2'b00;
    new_frame();
    pulse_start();
    wait_both_rdy("t3_rdy_a");
    rel = 2'b11;
    rel_cyc = cyc;
    tick();
    rel = 2'b00;
    wait_plots("t3_plots_a", 2);
    check("t3_p0_first_x", 32'(plot_x[0]), 0);
    check("t3_p0_next_x", 32'(plot_x[1]), 1);
    check("t3_p0_first_lat", plot_cyc[0], rel_cyc + 1);
    check("t3_p0_next_lat", plot_cyc[1], rel_cyc + 2);
    wait_both_rdy("t3_rdy_b");
    rel = 2'b01;
    tick();
    rel = 2'b00;
    wait_plots("t3_plots_b", 3);
    check("t3_single_x", 32'(plot_x[2]), 2);
    wait_both_rdy("t3_rdy_c");
    rel = 2'b11;
    wait_plots("t3_plots_c", 5);
    check("t3_p1_first_xy", {plot_x[3], 1'b0, plot_y[3]}, {8'd3, 1'b0, 7'd0});
    check("t3_p1_next_xy", {plot_x[4], 1'b0, plot_y[4]}, {8'd0, 1'b0, 7'd1});
    check("t3_p1_gap", plot_cyc[4] - plot_cyc[3], 1);
    wait_done("t3_done");
    check("t3_plots", plot_n, 8);

    // Asynchronous reset mid-frame after three dispatches.
    new_frame();
    pulse_start();
    n = 0;
    while (disp_n < 3 && n < 200) begin
      tick();
      n++;
    end
    check("t5_three_dispatched", disp_n, 3);
    rst_n = 1'b0;
    #1;
    check("t5_eng_px_async", 32'(eng_px), 0);
    check("t5_outputs_async", {eng_go, eng_res_ack, vga_plot, done, eng_py}, 0);
    check("t5_vga_async", {vga_x, vga_y, vga_colour}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    new_frame();
    pulse_start();
    n = 0;
    while (eng_go == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check("t5_first_go", 32'(eng_go), 1);
    check("t5_first_xy", {eng_px, 1'b0, eng_py}, 0);
    wait_done("t5_done");
    check("t5_plots", plot_n, 8);

    // start ignored in RUN; start in DONE begins a fresh frame.
    new_frame();
    pulse_start();
    n = 0;
    while (disp_n < 2 && n < 200) begin
      tick();
      n++;
    end
    pulse_start();
    check("t6_no_done_early", 32'(done), 0);
    wait_done("t6_done");
    check("t6_plots", plot_n, 8);
    check("t6_dispatches", disp_n, 8);
    new_frame();
    pulse_start();
    check("t6_done_fall", 32'(done), 0);
    wait_done("t6_done2");
    check("t6_plots2", plot_n, 8);
    repeat (3) tick();
    check("t6_idle_plots", plot_n, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
